cp0_tlb_regs: RTL and testbench

CP0 TLB management register bank sitting directly upstream of the MMU. It holds Index, Random, EntryLo0/1, Context, PageMask, Wired and EntryHi and services MTC0/MFC0 accesses. It sequences TLBWI/TLBWR into a one-cycle TLB write strobe toward the MMU. It also captures the faulting virtual page on TLB exceptions.

---
 rtl/cp0_tlb_regs_if.sv | 27 ++
 rtl/cp0_tlb_regs.sv | 210 +++++++++++++++++++++
 tb/tb_cp0_tlb_regs.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_tlb_regs_if.sv
// IMMU: CP0 <-> MMU TLB management bundle.
// cpu side drives the TLB register images and the one-cycle writeTlb strobe;
// the MMU side returns tlbMiss/tlbModified/tlbInvalid.
interface IMMU;
  logic [31:0] index;
  logic [31:0] random;
  logic [31:0] entryLo0;
  logic [31:0] entryLo1;
  logic [31:0] ctx;
  logic [31:0] pageMask;
  logic [31:0] wired;
  logic [31:0] entryHi;
  logic        writeTlb;
  logic        tlbMiss;
  logic        tlbModified;
  logic        tlbInvalid;

  modport cpu (
    output index, random, entryLo0, entryLo1, ctx, pageMask, wired, entryHi, writeTlb,
    input  tlbMiss, tlbModified, tlbInvalid
  );

  modport mmu (
    input  index, random, entryLo0, entryLo1, ctx, pageMask, wired, entryHi, writeTlb,
    output tlbMiss, tlbModified, tlbInvalid
  );
endinterface

// File: rtl/cp0_tlb_regs.sv
// cp0_tlb_regs: CP0 TLB management registers (Index, Random, EntryLo0/1, Context,
//   PageMask, Wired, EntryHi), MTC0/MFC0 access, TLBWI/TLBWR write sequencing and
//   TLB exception VPN capture.
// Latency: MTC0 visible the cycle after the write edge; TLB op accepted on edge N,
//   writeTlb/busy high for cycle N+1 only; rdata is combinational.
// Backpressure: tlbOp is ignored while busy; no other stalls.
// Ports: clk/res (sync active-high reset), we/wsel/wdata (MTC0), rsel/rdata (MFC0),
//   tlbOp/busy (TLB write sequencing), exc/badVAddr (exception capture),
//   it (IMMU.cpu toward the MMU).
// Build option: CP0_WIRED_EN implements the Wired register; without it Wired reads 0
//   and Random wraps over the full range.
module cp0_tlb_regs #(
  parameter int TLB_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        res,
  input  logic        we,
  input  logic [4:0]  wsel,
  input  logic [31:0] wdata,
  input  logic [4:0]  rsel,
  output logic [31:0] rdata,
  input  logic [1:0]  tlbOp,
  output logic        busy,
  input  logic        exc,
  input  logic [31:0] badVAddr,
  IMMU.cpu            it
);

  localparam int IW = $clog2(TLB_ENTRIES);
  localparam logic [IW-1:0] RAND_TOP = IW'(TLB_ENTRIES - 1);

  localparam logic [4:0] SEL_INDEX    = 5'd0;
  localparam logic [4:0] SEL_RANDOM   = 5'd1;
  localparam logic [4:0] SEL_ENTRYLO0 = 5'd2;
  localparam logic [4:0] SEL_ENTRYLO1 = 5'd3;
  localparam logic [4:0] SEL_CONTEXT  = 5'd4;
  localparam logic [4:0] SEL_PAGEMASK = 5'd5;
  localparam logic [4:0] SEL_WIRED    = 5'd6;
  localparam logic [4:0] SEL_ENTRYHI  = 5'd10;

  localparam logic [1:0] OP_TLBWI = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b10;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  // Register storage: only the architecturally writable/readable fields are kept.
  logic [IW-1:0] index_q;
  logic [IW-1:0] random_q;
  logic [25:0]   entrylo0_q;
  logic [25:0]   entrylo1_q;
  logic [8:0]    ptebase_q;
  logic [18:0]   badvpn2_q;
  logic [11:0]   pagemask_q;
  logic [18:0]   vpn2_q;
  logic [7:0]    asid_q;
  logic [IW-1:0] wired_q;
  logic          wired_force;

  state_t        state_q, state_d;
  logic [IW-1:0] wslot_q, wslot_d;

  logic wr_index, wr_entrylo0, wr_entrylo1, wr_context, wr_pagemask, wr_entryhi;

  assign wr_index    = we && (wsel == SEL_INDEX);
  assign wr_entrylo0 = we && (wsel == SEL_ENTRYLO0);
  assign wr_entrylo1 = we && (wsel == SEL_ENTRYLO1);
  assign wr_context  = we && (wsel == SEL_CONTEXT);
  assign wr_pagemask = we && (wsel == SEL_PAGEMASK);
  assign wr_entryhi  = we && (wsel == SEL_ENTRYHI);

  // Low badVAddr bits are below page granularity and never stored; the MMU
  // status returns are consumed elsewhere in the pipeline.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, badVAddr[12:0], it.tlbMiss, it.tlbModified, it.tlbInvalid};

`ifdef CP0_WIRED_EN
  logic wr_wired;
  assign wr_wired    = we && (wsel == SEL_WIRED);
  assign wired_force = wr_wired;

  always_ff @(posedge clk) begin
    if (res) begin
      wired_q <= '0;
    end else if (wr_wired) begin
      wired_q <= wdata[IW-1:0];
    end
  end
`else
  // With no Wired register the floor is 0, so Random wraps TOP -> 0 -> TOP.
  assign wired_q     = '0;
  assign wired_force = 1'b0;
`endif

  // Random counts down every cycle (busy or not) and reloads to the top once it
  // reaches the wired floor; wired >= TOP therefore pins it at the top.
  always_ff @(posedge clk) begin
    if (res) begin
      random_q <= RAND_TOP;
    end else if (wired_force || (random_q <= wired_q)) begin
      random_q <= RAND_TOP;
    end else begin
      random_q <= random_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      index_q    <= '0;
      entrylo0_q <= '0;
      entrylo1_q <= '0;
      ptebase_q  <= '0;
      badvpn2_q  <= '0;
      pagemask_q <= '0;
      vpn2_q     <= '0;
      asid_q     <= '0;
    end else begin
      if (wr_index)    index_q    <= wdata[IW-1:0];
      if (wr_entrylo0) entrylo0_q <= wdata[25:0];
      if (wr_entrylo1) entrylo1_q <= wdata[25:0];
      if (wr_context)  ptebase_q  <= wdata[31:23];
      if (wr_pagemask) pagemask_q <= wdata[24:13];
      if (wr_entryhi)  asid_q     <= wdata[7:0];
      // The faulting page overrides a simultaneous software write of VPN2.
      if (exc) begin
        badvpn2_q <= badVAddr[31:13];
        vpn2_q    <= badVAddr[31:13];
      end else if (wr_entryhi) begin
        vpn2_q <= wdata[31:13];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      wslot_q <= '0;
    end else begin
      state_q <= state_d;
      wslot_q <= wslot_d;
    end
  end

  // The slot is frozen at accept time so a Random tick or Index write during
  // WRITE cannot redirect the TLB write.
  always_comb begin
    state_d = state_q;
    wslot_d = wslot_q;
    case (state_q)
      IDLE: begin
        if (tlbOp == OP_TLBWI) begin
          wslot_d = index_q;
          state_d = WRITE;
        end else if (tlbOp == OP_TLBWR) begin
          wslot_d = random_q;
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == WRITE);

  logic [31:0] index_img, random_img, entrylo0_img, entrylo1_img;
  logic [31:0] context_img, pagemask_img, wired_img, entryhi_img;

  assign index_img    = 32'(index_q);
  assign random_img   = 32'(random_q);
  assign entrylo0_img = {6'd0, entrylo0_q};
  assign entrylo1_img = {6'd0, entrylo1_q};
  assign context_img  = {ptebase_q, badvpn2_q, 4'd0};
  assign pagemask_img = {7'd0, pagemask_q, 13'd0};
  assign wired_img    = 32'(wired_q);
  assign entryhi_img  = {vpn2_q, 5'd0, asid_q};

  always_comb begin
    rdata = 32'd0;
    case (rsel)
      SEL_INDEX:    rdata = index_img;
      SEL_RANDOM:   rdata = random_img;
      SEL_ENTRYLO0: rdata = entrylo0_img;
      SEL_ENTRYLO1: rdata = entrylo1_img;
      SEL_CONTEXT:  rdata = context_img;
      SEL_PAGEMASK: rdata = pagemask_img;
      SEL_WIRED:    rdata = wired_img;
      SEL_ENTRYHI:  rdata = entryhi_img;
      default:      rdata = 32'd0;
    endcase
  end

  // During WRITE the MMU sees the latched slot on index; otherwise Index itself.
  assign it.index    = busy ? 32'(wslot_q) : index_img;
  assign it.random   = random_img;
  assign it.entryLo0 = entrylo0_img;
  assign it.entryLo1 = entrylo1_img;
  assign it.ctx      = context_img;
  assign it.pageMask = pagemask_img;
  assign it.wired    = wired_img;
  assign it.entryHi  = entryhi_img;
  assign it.writeTlb = busy;

endmodule

// File: tb/tb_cp0_tlb_regs.sv
// tb_cp0_tlb_regs: self-checking bench for cp0_tlb_regs (TLB_ENTRIES = 64).
// Directed scenarios followed by randomized MTC0/TLB-op/exception/reset traffic,
// all compared against a register-level reference model every cycle.
module tb_cp0_tlb_regs;

  localparam int N    = 64;
  localparam int MAXR = N - 1;
`ifdef CP0_WIRED_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res;
  logic        we;
  logic [4:0]  wsel;
  logic [31:0] wdata;
  logic [4:0]  rsel;
  logic [31:0] rdata;
  logic [1:0]  tlbOp;
  logic        busy;
  logic        exc;
  logic [31:0] badVAddr;

  IMMU it_if();

  cp0_tlb_regs #(.TLB_ENTRIES(N)) dut (
    .clk      (clk),
    .res      (res),
    .we       (we),
    .wsel     (wsel),
    .wdata    (wdata),
    .rsel     (rsel),
    .rdata    (rdata),
    .tlbOp    (tlbOp),
    .busy     (busy),
    .exc      (exc),
    .badVAddr (badVAddr),
    .it       (it_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: architectural register values as full 32-bit images.
  int unsigned m_index, m_random, m_lo0, m_lo1, m_ctx, m_pmask, m_wired, m_ehi, m_slot;
  bit          m_busy;

  task automatic model_reset();
    m_index  = 0;
    m_random = MAXR;
    m_lo0    = 0;
    m_lo1    = 0;
    m_ctx    = 0;
    m_pmask  = 0;
    m_wired  = 0;
    m_ehi    = 0;
    m_slot   = 0;
    m_busy   = 1'b0;
  endtask

  task automatic model_edge();
    int unsigned nr;
    if (res) begin
      model_reset();
      return;
    end
    if (WEN && we && wsel == 5'd6) nr = MAXR;
    else if (m_random <= m_wired)  nr = MAXR;
    else                           nr = m_random - 1;
    if (m_busy) begin
      m_busy = 1'b0;
    end else if (tlbOp == 2'b01 || tlbOp == 2'b10) begin
      m_slot = (tlbOp == 2'b01) ? m_index : m_random;
      m_busy = 1'b1;
    end
    if (we) begin
      case (wsel)
        5'd0:  m_index = wdata % N;
        5'd2:  m_lo0   = wdata & 32'h03FF_FFFF;
        5'd3:  m_lo1   = wdata & 32'h03FF_FFFF;
        5'd4:  m_ctx   = (m_ctx & 32'h007F_FFF0) | (wdata & 32'hFF80_0000);
        5'd5:  m_pmask = wdata & 32'h01FF_E000;
        5'd6:  if (WEN) m_wired = wdata % N;
        5'd10: m_ehi   = wdata & 32'hFFFF_E0FF;
        default: ;
      endcase
    end
    if (exc) begin
      m_ehi = (m_ehi & 32'h0000_00FF) | (badVAddr & 32'hFFFF_E000);
      m_ctx = (m_ctx & 32'hFF80_0000) | ((badVAddr >> 13) << 4);
    end
    m_random = nr;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] sel);
    case (sel)
      5'd0:    return m_index;
      5'd1:    return m_random;
      5'd2:    return m_lo0;
      5'd3:    return m_lo1;
      5'd4:    return m_ctx;
      5'd5:    return m_pmask;
      5'd6:    return m_wired;
      5'd10:   return m_ehi;
      default: return 32'd0;
    endcase
  endfunction

  task automatic compare_all();
    check("it_index",    it_if.index,    m_busy ? m_slot : m_index);
    check("it_random",   it_if.random,   m_random);
    check("it_entryLo0", it_if.entryLo0, m_lo0);
    check("it_entryLo1", it_if.entryLo1, m_lo1);
    check("it_ctx",      it_if.ctx,      m_ctx);
    check("it_pageMask", it_if.pageMask, m_pmask);
    check("it_wired",    it_if.wired,    m_wired);
    check("it_entryHi",  it_if.entryHi,  m_ehi);
    check("it_writeTlb", 32'(it_if.writeTlb), 32'(m_busy));
    check("busy",        32'(busy),      32'(m_busy));
    check("rdata",       rdata,          exp_read(rsel));
  endtask

  // Inputs change just after the falling edge; the model advances on the rising
  // edge with the same inputs the DUT saw; outputs are compared at the next fall.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic mtc0(input logic [4:0] sel, input logic [31:0] data);
    we    = 1'b1;
    wsel  = sel;
    wdata = data;
    step();
    we    = 1'b0;
  endtask

  function automatic logic [4:0] pick_sel();
    int unsigned r;
    r = $urandom_range(0, 11);
    case (r)
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd2;
      3: return 5'd3;
      4: return 5'd4;
      5: return 5'd5;
      6, 7: return 5'd6;
      8, 9: return 5'd10;
      10: return 5'd7;
      default: return 5'd31;
    endcase
  endfunction

  logic [31:0] tmp;

  initial begin
    it_if.tlbMiss     = 1'b0;
    it_if.tlbModified = 1'b0;
    it_if.tlbInvalid  = 1'b0;
    res      = 1'b1;
    we       = 1'b0;
    wsel     = 5'd0;
    wdata    = 32'd0;
    rsel     = 5'd1;
    tlbOp    = 2'b00;
    exc      = 1'b0;
    badVAddr = 32'd0;
    model_reset();

    // Reset, then free-run: Random counts 63 down to 0 and wraps.
    step();
    res = 1'b0;
    check("rand_run", rdata, 32'd63);
    for (int k = 1; k <= 70; k++) begin
      step();
      check("rand_run", rdata, 32'(63 - (k % 64)));
    end

    // Wired = 8, then an ignored write to Random; watch a full wrap.
    mtc0(5'd6, 32'd8);
    mtc0(5'd1, 32'd5);
    for (int k = 0; k < 60; k++) step();

    // Field masking and TLBWI; an op presented while busy is dropped.
    mtc0(5'd0, 32'h0000_002A);
    mtc0(5'd10, 32'hFFFF_FFFF);
    mtc0(5'd2, 32'hFFFF_FFFF);
    rsel  = 5'd10;
    tlbOp = 2'b01;
    step();
    tlbOp = 2'b10;
    check("wi_writeTlb", 32'(it_if.writeTlb), 32'd1);
    check("wi_index", it_if.index, 32'h0000_002A);
    check("wi_busy", 32'(busy), 32'd1);
    check("ehi_mask", rdata, 32'hFFFF_E0FF);
    rsel = 5'd2;
    #1;
    check("lo0_mask", rdata, 32'h03FF_FFFF);
    step();
    tlbOp = 2'b00;
    check("busy_op_ignored", 32'(it_if.writeTlb), 32'd0);

    // TLBWR when Random is 17.
    rsel = 5'd1;
    for (int i = 0; i < 80 && m_random != 17; i++) step();
    tlbOp = 2'b10;
    step();
    tlbOp = 2'b00;
    check("wr_writeTlb", 32'(it_if.writeTlb), 32'd1);
    check("wr_index", it_if.index, 32'd17);
    step();
    check("wr_index_back", it_if.index, 32'h0000_002A);

    // Exception capture colliding with an MTC0 EntryHi.
    mtc0(5'd10, 32'h0000_005A);
    we       = 1'b1;
    wsel     = 5'd10;
    wdata    = 32'h0000_0033;
    exc      = 1'b1;
    badVAddr = 32'h8040_3123;
    rsel     = 5'd10;
    step();
    we  = 1'b0;
    exc = 1'b0;
    check("exc_entryHi", rdata, 32'h8040_2033);
    rsel = 5'd4;
    #1;
    tmp = rdata;
    check("exc_badvpn2", 32'(tmp[22:4]), 32'h0004_0201);

    // Reset while a write is in flight.
    tlbOp = 2'b01;
    step();
    tlbOp = 2'b00;
    check("pre_rst_writeTlb", 32'(it_if.writeTlb), 32'd1);
    res = 1'b1;
    step();
    res = 1'b0;
    check("rst_writeTlb", 32'(it_if.writeTlb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_random", it_if.random, 32'd63);
    step();
    check("post_rst_writeTlb", 32'(it_if.writeTlb), 32'd0);

    // Wired readback depends on the build option.
    mtc0(5'd6, 32'd8);
    rsel = 5'd6;
    #1;
    check("wired_rd", rdata, WEN ? 32'd8 : 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      res   = ($urandom_range(0, 199) == 0);
      we    = ($urandom_range(0, 2) == 0);
      wsel  = pick_sel();
      wdata = $urandom;
      if (wsel == 5'd6 && $urandom_range(0, 3) != 0) wdata = 32'($urandom_range(0, 63));
      tlbOp    = 2'($urandom_range(0, 3));
      exc      = ($urandom_range(0, 9) == 0);
      badVAddr = $urandom;
      rsel     = pick_sel();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
